// File: rtl/mti_canceller.sv
// Slow-time MTI canceller: bypass, two-pulse and three-pulse filters over
// per-range-bin I/Q delay lines. Outputs lag the accepted input by 3 cycles.
module mti_canceller #(
  parameter int WIDTH      = 25,
  parameter int RANGE_BINS = 256,
  parameter int PRF_N      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode,
  input  logic                         in_valid,
  input  logic                         in_sop,
  input  logic signed [WIDTH-1:0]      in_i,
  input  logic signed [WIDTH-1:0]      in_q,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic signed [WIDTH+1:0]      out_i,
  output logic signed [WIDTH+1:0]      out_q,
  output logic [2*(WIDTH+2)-1:0]       out_abs2,
  output logic [$clog2(PRF_N)-1:0]     out_pulse_idx,
  output logic                         group_done,
  output logic                         overrun
);

  localparam int OW = WIDTH + 2;
  localparam int SW = 2 * OW;
  localparam int AW = $clog2(RANGE_BINS);
  localparam int PW = $clog2(PRF_N);
  localparam logic [AW-1:0] LAST_BIN   = AW'(RANGE_BINS - 1);
  localparam logic [PW-1:0] LAST_PULSE = PW'(PRF_N - 1);

  logic [AW-1:0] range_cnt;
  logic [PW-1:0] pulse_cnt;
  logic          started;
  logic [1:0]    mode_q;

  logic          sop_in, range_full, accept, drop, blank;
  logic [PW-1:0] next_pulse, cur_pulse;
  logic [1:0]    cur_mode;
  logic [AW-1:0] addr;

  // Samples arriving before the first in_sop after reset have no pulse to join.
  always_comb begin
    sop_in     = in_valid & in_sop;
    range_full = (range_cnt == LAST_BIN);
    accept     = in_valid & (in_sop | (started & ~range_full));
    drop       = in_valid & ~in_sop & started & range_full;
    if (!started || pulse_cnt == LAST_PULSE)
      next_pulse = '0;
    else
      next_pulse = pulse_cnt + PW'(1);
    cur_pulse = sop_in ? next_pulse : pulse_cnt;
    cur_mode  = (sop_in && next_pulse == '0) ? mode : mode_q;
    addr      = sop_in ? '0 : range_cnt + AW'(1);
    blank     = (cur_mode == 2'd1 && cur_pulse == '0) ||
                (cur_mode == 2'd2 && cur_pulse <= PW'(1));
  end

  logic signed [WIDTH-1:0] l1_i [RANGE_BINS];
  logic signed [WIDTH-1:0] l1_q [RANGE_BINS];
  logic signed [WIDTH-1:0] l2_i [RANGE_BINS];
  logic signed [WIDTH-1:0] l2_q [RANGE_BINS];
  logic signed [WIDTH-1:0] d1_i, d1_q, d2_i, d2_q;

  assign d1_i = l1_i[addr];
  assign d1_q = l1_q[addr];
  assign d2_i = l2_i[addr];
  assign d2_q = l2_q[addr];

  // Delay lines are never reset; warm-up blanking hides stale contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      l1_i[addr] <= in_i;
      l1_q[addr] <= in_q;
      l2_i[addr] <= d1_i;
      l2_q[addr] <= d1_q;
    end
  end

  logic                    s1_acc, s1_val, s1_sop, s1_last;
  logic [PW-1:0]           s1_pidx;
  logic [1:0]              s1_mode;
  logic signed [WIDTH-1:0] s1_x_i, s1_x_q, s1_d1_i, s1_d1_q, s1_d2_i, s1_d2_q;

  logic                    s2_val, s2_sop, s2_last;
  logic [PW-1:0]           s2_pidx;
  logic signed [OW-1:0]    s2_i, s2_q;

  logic signed [OW-1:0] xi, xq, ai, aq, bi, bq, y_i, y_q;

  assign xi = {{2{s1_x_i[WIDTH-1]}}, s1_x_i};
  assign xq = {{2{s1_x_q[WIDTH-1]}}, s1_x_q};
  assign ai = {{2{s1_d1_i[WIDTH-1]}}, s1_d1_i};
  assign aq = {{2{s1_d1_q[WIDTH-1]}}, s1_d1_q};
  assign bi = {{2{s1_d2_i[WIDTH-1]}}, s1_d2_i};
  assign bq = {{2{s1_d2_q[WIDTH-1]}}, s1_d2_q};

  always_comb begin
    case (s1_mode)
      2'd1: begin
        y_i = xi - ai;
        y_q = xq - aq;
      end
      2'd2: begin
        y_i = xi - (ai <<< 1) + bi;
        y_q = xq - (aq <<< 1) + bq;
      end
      default: begin
        y_i = xi;
        y_q = xq;
      end
    endcase
  end

  logic signed [SW-1:0] e_i, e_q, sq_i, sq_q;
  logic [SW:0]          sum;
  logic [SW-1:0]        abs2_sat;
  logic                 gd;

  always_comb begin
    e_i      = SW'(s2_i);
    e_q      = SW'(s2_q);
    sq_i     = e_i * e_i;
    sq_q     = e_q * e_q;
    sum      = {1'b0, sq_i} + {1'b0, sq_q};
    abs2_sat = sum[SW] ? '1 : sum[SW-1:0];
    // A pulse ends at the last bin, or when the next in_sop shows up behind it.
    gd = s2_val && (s2_pidx == LAST_PULSE) &&
         (s2_last || (s1_acc && s1_sop) || (!s1_acc && sop_in));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_cnt     <= '0;
      pulse_cnt     <= '0;
      started       <= 1'b0;
      mode_q        <= 2'd0;
      overrun       <= 1'b0;
      s1_acc        <= 1'b0;
      s1_val        <= 1'b0;
      s1_sop        <= 1'b0;
      s1_last       <= 1'b0;
      s1_pidx       <= '0;
      s1_mode       <= 2'd0;
      s1_x_i        <= '0;
      s1_x_q        <= '0;
      s1_d1_i       <= '0;
      s1_d1_q       <= '0;
      s1_d2_i       <= '0;
      s1_d2_q       <= '0;
      s2_val        <= 1'b0;
      s2_sop        <= 1'b0;
      s2_last       <= 1'b0;
      s2_pidx       <= '0;
      s2_i          <= '0;
      s2_q          <= '0;
      out_valid     <= 1'b0;
      out_sop       <= 1'b0;
      out_i         <= '0;
      out_q         <= '0;
      out_abs2      <= '0;
      out_pulse_idx <= '0;
      group_done    <= 1'b0;
    end else begin
      if (sop_in) begin
        range_cnt <= '0;
        pulse_cnt <= next_pulse;
        started   <= 1'b1;
        if (next_pulse == '0)
          mode_q <= mode;
      end else if (accept) begin
        range_cnt <= range_cnt + AW'(1);
      end
      if (drop)
        overrun <= 1'b1;

      s1_acc <= accept;
      s1_val <= accept & ~blank;
      s1_sop <= sop_in;
      if (accept) begin
        s1_last <= (addr == LAST_BIN);
        s1_pidx <= cur_pulse;
        s1_mode <= cur_mode;
        s1_x_i  <= in_i;
        s1_x_q  <= in_q;
        s1_d1_i <= d1_i;
        s1_d1_q <= d1_q;
        s1_d2_i <= d2_i;
        s1_d2_q <= d2_q;
      end

      s2_val  <= s1_val;
      s2_sop  <= s1_val & s1_sop;
      s2_last <= s1_last;
      s2_pidx <= s1_pidx;
      s2_i    <= y_i;
      s2_q    <= y_q;

      out_valid     <= s2_val;
      out_sop       <= s2_sop;
      out_i         <= s2_i;
      out_q         <= s2_q;
      out_abs2      <= abs2_sat;
      out_pulse_idx <= s2_pidx;
      group_done    <= gd;
    end
  end

endmodule

// File: tb/tb_mti_canceller.sv
// Directed bench for mti_canceller (WIDTH=16, RANGE_BINS=8, PRF_N=4) with
// hand-computed expectations checked three cycles after each driven sample.
module tb_mti_canceller;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [1:0]         mode = 2'd0;
  logic               in_valid = 1'b0;
  logic               in_sop = 1'b0;
  logic signed [15:0] in_i = '0;
  logic signed [15:0] in_q = '0;
  logic               out_valid, out_sop, group_done, overrun;
  logic signed [17:0] out_i, out_q;
  logic [35:0]        out_abs2;
  logic [1:0]         out_pulse_idx;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic               v;
    logic               sop;
    logic signed [17:0] i;
    logic signed [17:0] q;
    logic [35:0]        a;
    logic [1:0]         idx;
    logic               gd;
  } exp_t;

  exp_t pend[$];

  mti_canceller #(.WIDTH(16), .RANGE_BINS(8), .PRF_N(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_sop(in_sop), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .out_sop(out_sop), .out_i(out_i), .out_q(out_q),
    .out_abs2(out_abs2), .out_pulse_idx(out_pulse_idx),
    .group_done(group_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(logic v, logic s, int i, int q, longint a, int idx, logic gd);
    exp_t e;
    e.v = v; e.sop = s; e.i = 18'(i); e.q = 18'(q);
    e.a = 36'(a); e.idx = 2'(idx); e.gd = gd;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Check the output belonging to the sample driven three steps ago, then drive.
  task automatic step(logic v, logic s, int i, int q, exp_t e);
    exp_t o;
    @(negedge clk);
    if (pend.size() == 3) begin
      o = pend.pop_front();
      chk("out_valid", 64'(out_valid), 64'(o.v));
      chk("group_done", 64'(group_done), 64'(o.gd));
      if (o.v) begin
        chk("out_sop", 64'(out_sop), 64'(o.sop));
        chk("out_i", 64'(out_i), 64'(o.i));
        chk("out_q", 64'(out_q), 64'(o.q));
        chk("out_abs2", 64'(out_abs2), 64'(o.a));
        chk("out_pulse_idx", 64'(out_pulse_idx), 64'(o.idx));
      end
    end
    in_valid = v; in_sop = s; in_i = 16'(i); in_q = 16'(q);
    pend.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, ex(1'b0, 1'b0, 0, 0, 0, 0, 1'b0));
  endtask

  task automatic flush();
    repeat (3) idle();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_i = '0; in_q = '0;
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_sop", 64'(out_sop), 64'd0);
    chk("rst out_i", 64'(out_i), 64'd0);
    chk("rst out_q", 64'(out_q), 64'd0);
    chk("rst out_abs2", 64'(out_abs2), 64'd0);
    chk("rst out_pulse_idx", 64'(out_pulse_idx), 64'd0);
    chk("rst group_done", 64'(group_done), 64'd0);
    chk("rst overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pend.delete();
  endtask

  int g2i[4] = '{7, 20, 50, 30};
  int g2q[4] = '{-1, 3, 3, -10};
  int e2i[4] = '{0, 13, 30, -20};
  int e2q[4] = '{0, 4, 0, -13};
  int e2a[4] = '{0, 185, 900, 569};

  initial begin
    reset_dut();

    // bypass: single sample, ignored sop without valid, gap, extreme negative value
    mode = 2'd0;
    step(1'b1, 1'b1, -3, 4, ex(1'b1, 1'b1, -3, 4, 25, 0, 1'b0));
    step(1'b0, 1'b1, 99, 99, ex(1'b0, 1'b0, 0, 0, 0, 0, 1'b0));
    step(1'b1, 1'b0, -32768, -32768, ex(1'b1, 1'b0, -32768, -32768, 64'd2147483648, 0, 1'b0));
    flush();

    // mode 1, constant input, one full group
    reset_dut();
    mode = 2'd1;
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 8; b++)
        step(1'b1, b == 0, 100, -50, ex(p != 0, b == 0, 0, 0, 0, p, p == 3 && b == 7));
    flush();

    // mode written to 2 mid-group: group stays mode 1, short pulses
    for (int p = 0; p < 4; p++) begin
      if (p == 1) mode = 2'd2;
      for (int b = 0; b < 4; b++)
        step(1'b1, b == 0, g2i[p], g2q[p],
             ex(p != 0, b == 0, e2i[p], e2q[p], e2a[p], p, p == 3 && b == 3));
    end
    // next group in mode 2: I ramp cancels, Q squares leave second difference 2
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 8; b++)
        step(1'b1, b == 0, 10 * p, (p + 1) * (p + 1),
             ex(p >= 2, b == 0, 0, 2, 4, p, p == 3 && b == 7));
    flush();

    // overrun: 9 samples into 8 bins
    reset_dut();
    mode = 2'd0;
    for (int b = 0; b < 8; b++)
      step(1'b1, b == 0, b + 1, 0, ex(1'b1, b == 0, b + 1, 0, (b + 1) * (b + 1), 0, 1'b0));
    step(1'b1, 1'b0, 9, 0, ex(1'b0, 1'b0, 0, 0, 0, 0, 1'b0));
    flush();
    chk("overrun set", 64'(overrun), 64'd1);
    step(1'b1, 1'b1, 2, 0, ex(1'b1, 1'b1, 2, 0, 4, 1, 1'b0));
    flush();
    chk("overrun sticky", 64'(overrun), 64'd1);

    // reset in the middle of pulse 2, then full warm-up from pulse 0
    reset_dut();
    mode = 2'd1;
    for (int b = 0; b < 4; b++)
      step(1'b1, b == 0, 5, 5, ex(1'b0, 1'b0, 0, 0, 0, 0, 1'b0));
    for (int b = 0; b < 4; b++)
      step(1'b1, b == 0, 5, 5, ex(1'b1, b == 0, 0, 0, 0, 1, 1'b0));
    for (int b = 0; b < 2; b++)
      step(1'b1, b == 0, 9, 9, ex(1'b1, b == 0, 4, 4, 32, 2, 1'b0));
    reset_dut();
    for (int b = 0; b < 2; b++)
      step(1'b1, b == 0, 40, 2, ex(1'b0, 1'b0, 0, 0, 0, 0, 1'b0));
    for (int b = 0; b < 2; b++)
      step(1'b1, b == 0, 45, 2, ex(1'b1, b == 0, 5, 0, 25, 1, 1'b0));
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mti_canceller.md
MTI_CANCELLER -- requirements
Module: mti_canceller

Interface
REQ-001 Parameter WIDTH, default 25: signed width of the in_i and in_q samples.
REQ-002 Parameter RANGE_BINS, default 256: maximum number of samples per pulse repetition interval.
REQ-003 Parameter PRF_N, default 16: number of pulses per coherent group.
REQ-004 Port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port mode, input, 2 bits: 0 bypass, 1 two-pulse canceller, 2 three-pulse canceller, 3 treated as bypass.
REQ-007 Port in_valid, input, 1 bit: in_i and in_q carry a sample this cycle.
REQ-008 Port in_sop, input, 1 bit: first sample of a pulse; qualified by in_valid.
REQ-009 Ports in_i and in_q, input, WIDTH bits each: signed pulse-compressed I and Q samples.
REQ-010 Port out_valid, output, 1 bit: out_i, out_q and out_abs2 are valid this cycle.
REQ-011 Port out_sop, output, 1 bit: first output sample of a pulse.
REQ-012 Ports out_i and out_q, output, WIDTH+2 bits each: signed canceller output.
REQ-013 Port out_abs2, output, 2*(WIDTH+2) bits: unsigned out_i^2 + out_q^2, saturated.
REQ-014 Port out_pulse_idx, output, clog2(PRF_N) bits: index of the output pulse within its group.
REQ-015 Port group_done, output, 1 bit: one-cycle pulse on the last output sample of pulse PRF_N-1.
REQ-016 Port overrun, output, 1 bit: sticky error flag.

Function
REQ-017 Range counter: set to 0 on in_valid&in_sop; otherwise increments on each in_valid sample.
REQ-018 Pulse counter: increments on each in_valid&in_sop except the first after reset; wraps from PRF_N-1 to 0.
REQ-019 Delay lines: two RANGE_BINS-deep I/Q memories hold x[n-1] and x[n-2], both addressed by the range counter.
REQ-020 Delay-line update: on each accepted sample, line1[r] is read into the pipeline, then line2[r] <= line1[r] and line1[r] <= x[n].
REQ-021 Arithmetic, mode 1: y = x[n] - x[n-1].
REQ-022 Arithmetic, mode 2: y = x[n] - 2*x[n-1] + x[n-2].
REQ-023 Arithmetic, bypass: y = x[n], sign-extended.
REQ-024 Arithmetic width: all arithmetic is full-precision at WIDTH+2 bits; no truncation.
REQ-025 out_abs2: saturates to all-ones if the sum exceeds its width.
REQ-026 Mode latching: mode is sampled only at in_valid&in_sop when the pulse counter becomes 0; it is constant for the whole group.
REQ-027 Warm-up blanking: in mode 1, pulse 0 of each group produces no output; in mode 2, pulses 0 and 1 produce no output.
REQ-028 Warm-up delay-line writes: the delay lines are still written during warm-up pulses.
REQ-029 Latency: out_valid, out_sop, out_pulse_idx, out_i, out_q and out_abs2 are aligned and lag the input sample by exactly 3 cycles.
REQ-030 Throughput: one sample per cycle; back-to-back in_valid is fully supported; gaps in in_valid are preserved in the output.
REQ-031 Overrun: a sample with range counter already at RANGE_BINS-1 and no in_sop is discarded and sets overrun.
REQ-032 Overrun clearing: overrun is cleared only by reset.
REQ-033 Short pulses: if a pulse is shorter than RANGE_BINS, unused bins keep stale data, and the next pulse restarts at bin 0.
REQ-034 in_sop without in_valid: ignored.
REQ-035 in_sop on consecutive valid cycles: each starts a new pulse of length 1.
REQ-036 group_done: asserted together with out_valid on the last sample of pulse PRF_N-1, in the cycle before the next in_sop propagates.

Reset
REQ-037 While rst_n is low, the following are 0: out_valid, out_sop, out_i, out_q, out_abs2, out_pulse_idx, group_done, overrun, the range and pulse counters, and the pipeline registers.
REQ-038 Latched mode resets to bypass.
REQ-039 Delay-line memory contents are not cleared; warm-up blanking guarantees stale data is never output.
REQ-040 Reset mid-pulse: the in-flight pipeline is discarded; the first in_sop after release starts pulse 0 with full warm-up.

Verification
REQ-041 Mode 1, PRF_N=4, RANGE_BINS=8, constant I=100, Q=-50 for 4 pulses of 8 samples -> pulse 0 blanked; pulses 1-3 output I=0, Q=0, abs2=0; group_done once.
REQ-042 Mode 2, pulse n has I=10*n at every bin -> pulses 0-1 blanked; pulses 2-3 output I=0; a linear ramp gives zero second difference.
REQ-043 Bypass, single sample I=-3, Q=4 -> out_i=-3, out_q=4, out_abs2=25, exactly 3 cycles later.
REQ-044 Mode written to 2 mid-group while running mode 1 -> rest of group stays mode 1; the next group blanks 2 pulses and applies the three-pulse filter.
REQ-045 Pulse of 9 samples with RANGE_BINS=8 -> 9th sample produces no output and overrun=1 until reset.
REQ-046 rst_n low for 1 cycle mid-pulse 2 -> all outputs 0 within that cycle; the next in_sop yields out_pulse_idx=0 and full warm-up.
